// File: rtl/gate_tt_sweeper_if.sv
`default_nettype none
// =============================================================================
// Interface : gate_tt_sweeper_if
// Host/gate-facing signal bundle of the truth-table sweeper.
// Option    : GATE_TT_SWEEPER_MISMATCH_CNT_EN adds mismatch_cnt
// Revision  : 1.0
// =============================================================================
interface gate_tt_sweeper_if;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [3:0]  err_idx;
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
    logic [4:0]  mismatch_cnt;

    modport master (output start, abort, expected, dut_out,
                    input  dut_in, busy, done, pass, tt, err_idx, mismatch_cnt);
    modport slave  (input  start, abort, expected, dut_out,
                    output dut_in, busy, done, pass, tt, err_idx, mismatch_cnt);
`else
    modport master (output start, abort, expected, dut_out,
                    input  dut_in, busy, done, pass, tt, err_idx);
    modport slave  (input  start, abort, expected, dut_out,
                    output dut_in, busy, done, pass, tt, err_idx);
`endif
endinterface
`default_nettype wire

// File: rtl/gate_tt_sweeper.sv
`default_nettype none
// =============================================================================
// Module   : gate_tt_sweeper
// Sweeps all 16 vectors of a 4-input gate, builds its truth table, checks it.
// Option   : GATE_TT_SWEEPER_MISMATCH_CNT_EN adds a mismatch popcount output
// Revision : 1.0
// =============================================================================
module gate_tt_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input wire               clk,
    input wire               rst,
    gate_tt_sweeper_if.slave sw
);

    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [3:0]       r_dut_in;
    logic [15:0]      r_exp;
    logic [15:0]      r_tt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err_idx;
    logic             w_start_acc;
    logic             w_abort;
    logic [15:0]      w_diff;
    logic [3:0]       w_err_idx;
    logic [3:0]       w_bit_pos;

    // The done cycle is already IDLE, but a start seen there is still dropped.
    assign w_start_acc = (r_state == S_IDLE) && sw.start && !r_done;
    assign w_abort     = sw.abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE));
    assign w_diff      = r_tt ^ r_exp;
    assign w_bit_pos   = 4'd15 - r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_abort)                     w_state_nxt = S_IDLE;
                else if (r_cnt == c_SETTLE_LAST) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_abort)            w_state_nxt = S_IDLE;
                else if (r_idx == 4'hF) w_state_nxt = S_FINISH;
                else                    w_state_nxt = S_SETTLE;
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ascending scan: the highest differing bit is written last, i.e. the lowest input index.
    always_comb begin
        w_err_idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (w_diff[k[3:0]]) w_err_idx = 4'd15 - k[3:0];
        end
    end

`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
    logic [4:0] r_mism;
    logic [4:0] w_popcnt;

    always_comb begin
        w_popcnt = 5'd0;
        for (int k = 0; k < 16; k++) begin
            w_popcnt = w_popcnt + {4'd0, w_diff[k[3:0]]};
        end
    end

    assign sw.mismatch_cnt = r_mism;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= 4'd0;
            r_dut_in  <= 4'd0;
            r_exp     <= 16'd0;
            r_tt      <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_idx <= 4'd0;
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
            r_mism    <= 5'd0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_exp    <= sw.expected;
                        r_tt     <= 16'd0;
                        r_idx    <= 4'd0;
                        r_dut_in <= 4'd0;
                        r_cnt    <= '0;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
                        r_mism   <= 5'd0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (w_abort) begin
                        r_dut_in <= 4'd0;
                        r_busy   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    if (w_abort) begin
                        r_dut_in <= 4'd0;
                        r_busy   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_tt[w_bit_pos] <= sw.dut_out;
                        if (r_idx != 4'hF) begin
                            r_idx    <= r_idx + 4'd1;
                            r_dut_in <= r_idx + 4'd1;
                            r_cnt    <= '0;
                        end
                    end
                end
                S_FINISH: begin
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_pass    <= (r_tt == r_exp);
                    r_err_idx <= w_err_idx;
                    r_idx     <= 4'd0;
                    r_dut_in  <= 4'd0;
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
                    r_mism    <= w_popcnt;
`endif
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign sw.dut_in  = r_dut_in;
    assign sw.busy    = r_busy;
    assign sw.done    = r_done;
    assign sw.pass    = r_pass;
    assign sw.tt      = r_tt;
    assign sw.err_idx = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_sweeper.sv
`default_nettype none
// =============================================================================
// Module   : tb_gate_tt_sweeper
// Scoreboard bench: a settle-4 sweeper with a combinational gate model and a
// settle-1 sweeper with a one-cycle-delayed gate model.
// Revision : 1.0
// =============================================================================
module tb_gate_tt_sweeper;

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        logic [3:0]  err;
        logic [4:0]  mism;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc0 = 0;
    int          acc1 = 0;
    logic [15:0] model0 = 16'd0;
    logic [15:0] model1 = 16'd0;
    logic        d1 = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0;
    exp_t        e1;
    logic [4:0]  mc0;
    logic [4:0]  mc1;

    gate_tt_sweeper_if s0 ();
    gate_tt_sweeper_if s1 ();

    gate_tt_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .sw(s0));
    gate_tt_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .sw(s1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s0.dut_out = model0[4'd15 - s0.dut_in];
    always @(posedge clk) d1 <= model1[4'd15 - s1.dut_in];
    assign s1.dut_out = d1;

`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
    assign mc0 = s0.mismatch_cnt;
    assign mc1 = s1.mismatch_cnt;
`else
    assign mc0 = 5'd0;
    assign mc1 = 5'd0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic check_result(input string nm, input exp_t e, input logic [15:0] tt,
                                input logic p, input logic [3:0] ei, input logic [4:0] mc);
        chk({nm, "_tt"},      32'(tt), 32'(e.tt));
        chk({nm, "_pass"},    32'(p),  32'(e.pass));
        chk({nm, "_err_idx"}, 32'(ei), 32'(e.err));
        chk({nm, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
        chk({nm, "_mismatch_cnt"}, 32'(mc), 32'(e.mism));
`endif
    endtask

    // Scoreboard monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && s0.done) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done0: done=1 with no sweep outstanding");
            end else begin
                e0 = q0.pop_front();
                check_result("sweep0", e0, s0.tt, s0.pass, s0.err_idx, mc0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s1.done) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: done=1 with no sweep outstanding");
            end else begin
                e1 = q1.pop_front();
                check_result("sweep1", e1, s1.tt, s1.pass, s1.err_idx, mc1);
            end
        end
    end

    task automatic sweep0(input logic [15:0] model, input logic [15:0] expw, input bit push,
                          input logic [15:0] x_tt, input logic x_pass, input logic [3:0] x_err,
                          input logic [4:0] x_mism);
        exp_t e;
        @(negedge clk);
        model0      = model;
        s0.expected = expw;
        s0.start    = 1'b1;
        acc0        = cyc + 1;
        e.tt = x_tt; e.pass = x_pass; e.err = x_err; e.mism = x_mism;
        e.acc = acc0; e.lat = 81;
        if (push) q0.push_back(e);
        @(negedge clk);
        s0.start = 1'b0;
        chk("busy_after_start0", 32'(s0.busy), 32'd1);
    endtask

    task automatic sweep1(input logic [15:0] model, input logic [15:0] expw,
                          input logic [15:0] x_tt, input logic x_pass, input logic [3:0] x_err,
                          input logic [4:0] x_mism);
        exp_t e;
        @(negedge clk);
        model1      = model;
        s1.expected = expw;
        s1.start    = 1'b1;
        acc1        = cyc + 1;
        e.tt = x_tt; e.pass = x_pass; e.err = x_err; e.mism = x_mism;
        e.acc = acc1; e.lat = 33;
        q1.push_back(e);
        @(negedge clk);
        s1.start = 1'b0;
    endtask

    task automatic wait_done(input bit which, input string nm);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((which == 1'b0) ? s0.done : s1.done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: done not seen within 200 cycles", nm);
    endtask

    task automatic wait_idx0(input logic [3:0] v, input string nm);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s0.dut_in == v) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: dut_in never reached %0h", nm, v);
    endtask

    task automatic check_zero0(input string nm);
        chk({nm, "_dut_in"},  32'(s0.dut_in),  32'd0);
        chk({nm, "_busy"},    32'(s0.busy),    32'd0);
        chk({nm, "_done"},    32'(s0.done),    32'd0);
        chk({nm, "_pass"},    32'(s0.pass),    32'd0);
        chk({nm, "_tt"},      32'(s0.tt),      32'd0);
        chk({nm, "_err_idx"}, 32'(s0.err_idx), 32'd0);
`ifdef GATE_TT_SWEEPER_MISMATCH_CNT_EN
        chk({nm, "_mismatch_cnt"}, 32'(mc0), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s0.start = 1'b0; s0.abort = 1'b0; s0.expected = 16'd0;
        s1.start = 1'b0; s1.abort = 1'b0; s1.expected = 16'd0;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        rst = 1'b0;

        // Matching sweep, then a start in the done cycle must be dropped.
        sweep0(16'h9917, 16'h9917, 1'b1, 16'h9917, 1'b1, 4'd0, 5'd0);
        wait_done(1'b0, "sweep_match");
        s0.start = 1'b1;
        @(negedge clk);
        s0.start = 1'b0;
        chk("start_in_done_ignored_busy", 32'(s0.busy), 32'd0);
        repeat (3) @(negedge clk);

        // Fully inverted gate, then a single-bit mismatch at index 15.
        sweep0(16'h66E8, 16'h9917, 1'b1, 16'h66E8, 1'b0, 4'd0, 5'd16);
        wait_done(1'b0, "sweep_inverted");
        sweep0(16'h9917, 16'h9916, 1'b1, 16'h9917, 1'b0, 4'd15, 5'd1);
        wait_done(1'b0, "sweep_last_bit");

        // Abort in SETTLE of vector 7: partial tt kept, err_idx untouched, no done.
        sweep0(16'h9917, 16'h9917, 1'b0, 16'h0, 1'b0, 4'd0, 5'd0);
        wait_idx0(4'd7, "abort_wait");
        s0.abort = 1'b1;
        @(negedge clk);
        s0.abort = 1'b0;
        chk("abort_busy",    32'(s0.busy),    32'd0);
        chk("abort_dut_in",  32'(s0.dut_in),  32'd0);
        chk("abort_pass",    32'(s0.pass),    32'd0);
        chk("abort_tt",      32'(s0.tt),      32'h9800);
        chk("abort_err_idx", 32'(s0.err_idx), 32'd15);
        repeat (20) @(negedge clk);
        sweep0(16'h9917, 16'h9917, 1'b1, 16'h9917, 1'b1, 4'd0, 5'd0);
        wait_done(1'b0, "sweep_after_abort");

        // Start re-pulse mid-sweep is ignored; reset mid-sweep clears everything.
        sweep0(16'h9917, 16'h9917, 1'b0, 16'h0, 1'b0, 4'd0, 5'd0);
        wait_idx0(4'd3, "repulse_wait");
        s0.start = 1'b1;
        @(negedge clk);
        s0.start = 1'b0;
        wait_idx0(4'd9, "rst_wait");
        chk("no_restart_timing", 32'(cyc - acc0), 32'd45);
        rst = 1'b1;
        @(negedge clk);
        check_zero0("mid_rst");
        rst = 1'b0;
        sweep0(16'h9917, 16'h9916, 1'b1, 16'h9917, 1'b0, 4'd15, 5'd1);
        wait_done(1'b0, "sweep_after_rst");

        // Settle-1 sweeper against a registered gate model.
        sweep1(16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b1, 4'd0, 5'd0);
        wait_done(1'b1, "sweep1_match");
        sweep1(16'h8000, 16'h8400, 16'h8000, 1'b0, 4'd5, 5'd1);
        wait_done(1'b1, "sweep1_mismatch");

        repeat (5) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_tt_sweeper.md
Name: gate_tt_sweeper

Overview:
Sequencer that characterises one synthesized 4-input gate netlist by sweeping all 16 input vectors, waiting a settle interval per vector and sampling the single output. It assembles the 16-bit truth-table word and compares it against an expected word, for example 16'h9917. It sits between the gate under test (driven through dut_in/dut_out) and the equivalence-check host logic.

Parameters:
SETTLE_CYCLES, 4, cycles dut_in is held before each sample; legal range 1..255.
CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  sweep request; accepted only in IDLE.
abort  input  1  synchronous cancel of a running sweep.
expected  input  16  reference truth table; latched on start acceptance.
dut_in  output  4  input vector to the gate; {_0,_1,_2,_3} = dut_in[3:0], so _0 is the MSB.
dut_out  input  1  gate output.
busy  output  1  high from the cycle after start acceptance until the cycle done asserts.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  tt == expected latch; valid from done, held until the next start acceptance.
tt  output  16  captured truth table, MSB-first: tt[15-i] = f(i), where i = dut_in.
err_idx  output  4  lowest input index i with a mismatch; 0 when pass=1.

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, pass=0, tt=0, err_idx=0, state=IDLE, idx=0, cnt=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE + start=1:
  - latch expected, clear tt, set idx=0, dut_in=0, cnt=0, pass=0.
  - next state is SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - when cnt == SETTLE_CYCLES-1, next state is SAMPLE.
  - dut_in is stable for the whole interval.
- SAMPLE:
  - tt[15-idx] <= dut_out.
  - if idx == 15, next state is FINISH.
  - otherwise idx <= idx+1, dut_in <= idx+1, cnt <= 0, next state is SETTLE.
- FINISH (one cycle):
  - done=1, busy=0.
  - pass <= (tt == expected_latched).
  - err_idx <= smallest i with tt[15-i] != expected_latched[15-i], or 0 if none.
  - next state is IDLE; dut_in returns to 0.
- Latency: each vector costs SETTLE_CYCLES+1 cycles. With start accepted at edge 0, done is high in the cycle after edge 16*(SETTLE_CYCLES+1)+1.
  - Default SETTLE_CYCLES=4: done at edge 81.
- start while busy or in FINISH: ignored, no queuing.
- start in the same cycle as done: ignored. A new sweep needs start in IDLE.
- abort in SETTLE or SAMPLE:
  - next state is IDLE, dut_in=0, busy=0.
  - done is not pulsed, pass=0, tt keeps its partial contents, err_idx unchanged.
- abort in IDLE or FINISH: no effect; FINISH still completes.
- abort and start together in IDLE: start wins.
- rst mid-sweep: all outputs return to their reset values on the next edge.
- idx wraps only through FINISH; never 15 -> 0 inside the sweep.
- err_idx priority: lowest index wins.

Optional Feature:
Macro: GATE_TT_SWEEPER_MISMATCH_CNT_EN.
- Defined:
  - adds output mismatch_cnt[4:0], reset 0, cleared on start acceptance.
  - mismatch_cnt is popcount(tt ^ expected_latched), updated in FINISH.
  - range 0..16; 16 means the output is fully inverted.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Gate model 0x9917, expected=16'h9917, SETTLE_CYCLES=4, start pulse → done at edge 81, tt=16'h9917, pass=1, err_idx=0.
- Same model, expected=16'h9916 → pass=0, err_idx=15, mismatch_cnt=1 (macro on).
- Model is the inverted 0x9917 (0x66E8), expected=16'h9917 → pass=0, err_idx=0, mismatch_cnt=16.
- abort asserted while dut_in=7 in SETTLE → next cycle busy=0, dut_in=0, no done pulse, pass=0; a later start gives a full correct sweep.
- start re-pulsed at dut_in=3, then rst at dut_in=9 → the re-pulse causes no restart (sweep runs normally up to 9); rst zeroes all outputs; the next sweep is unaffected.
- SETTLE_CYCLES=1 with a dut_out model delayed by 1 cycle → every dut_in value is held 1 cycle and its sample is taken in the following cycle; tt equals the model word; done at edge 33.
